// File: rtl/if_id_pipe_reg_pkg.sv
// if_id_pipe_reg_pkg: NOP encoding, opcodes, IF/ID FSM states and
// the source-register read decode shared with decode and hazard logic.
package if_id_pipe_reg_pkg;

  localparam logic [15:0] NOP = 16'h0800;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_HALT = 5'b00000;
  localparam opcode_t OP_NOP  = 5'b00001;
  localparam opcode_t OP_SIIC = 5'b00010;
  localparam opcode_t OP_RTI  = 5'b00011;
  localparam opcode_t OP_J    = 5'b00100;
  localparam opcode_t OP_JAL  = 5'b00110;
  localparam opcode_t OP_ST   = 5'b10000;
  localparam opcode_t OP_STU  = 5'b10011;
  localparam opcode_t OP_LBI  = 5'b11000;
  localparam opcode_t OP_SHFT = 5'b11010;
  localparam opcode_t OP_ALU  = 5'b11011;
  localparam opcode_t OP_SEQ  = 5'b11100;
  localparam opcode_t OP_SLT  = 5'b11101;
  localparam opcode_t OP_SLE  = 5'b11110;
  localparam opcode_t OP_SCO  = 5'b11111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic reads_rs(
    input opcode_t op
  );
    case (op)
      OP_HALT, OP_NOP, OP_SIIC, OP_RTI,
      OP_J, OP_JAL, OP_LBI: reads_rs = 1'b0;
      default:              reads_rs = 1'b1;
    endcase
  endfunction

  function automatic logic reads_rt(
    input opcode_t op
  );
    case (op)
      OP_ALU, OP_SHFT, OP_SEQ, OP_SLT,
      OP_SLE, OP_SCO, OP_ST, OP_STU:
               reads_rt = 1'b1;
      default: reads_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// if_id_pipe_reg_if: fetch-side inputs, stall/flush controls and the
// registered decode-side outputs; master drives, slave is the stage.
interface if_id_pipe_reg_if #(
  parameter int DATA_W = 16
`ifdef IF_ID_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);

  logic [DATA_W-1:0] instr_in;
  logic [DATA_W-1:0] pc_plus2_in;
  logic              fetch_valid_in;
  logic              stall;
  logic              flush;

  logic [DATA_W-1:0] instr_out;
  logic [DATA_W-1:0] pc_plus2_out;
  logic              valid_out;
  logic [2:0]        Rs_out;
  logic [2:0]        Rt_out;
  logic              ReadingRs_out;
  logic              ReadingRt_out;
  logic              stall_timeout;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output instr_in, pc_plus2_in,
    output fetch_valid_in, stall, flush,
    input  instr_out, pc_plus2_out,
    input  valid_out, Rs_out, Rt_out,
    input  ReadingRs_out, ReadingRt_out,
    input  stall_timeout,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  instr_in, pc_plus2_in,
    input  fetch_valid_in, stall, flush,
    output instr_out, pc_plus2_out,
    output valid_out, Rs_out, Rt_out,
    output ReadingRs_out, ReadingRt_out,
    output stall_timeout,
    output stall_cycles, flush_count
  );
`else
  modport master (
    output instr_in, pc_plus2_in,
    output fetch_valid_in, stall, flush,
    input  instr_out, pc_plus2_out,
    input  valid_out, Rs_out, Rt_out,
    input  ReadingRs_out, ReadingRt_out,
    input  stall_timeout
  );

  modport slave (
    input  instr_in, pc_plus2_in,
    input  fetch_valid_in, stall, flush,
    output instr_out, pc_plus2_out,
    output valid_out, Rs_out, Rt_out,
    output ReadingRs_out, ReadingRt_out,
    output stall_timeout
  );
`endif

endinterface

// File: rtl/if_id_src_decode.sv
// if_id_src_decode: combinational Rs/Rt field extract and read flags.
// Ports: i_instr_hi = instr[15:5], i_valid; o_rs/o_rt/o_reading_*.
module if_id_src_decode
  import if_id_pipe_reg_pkg::*;
(
  input  logic [10:0] i_instr_hi,
  input  logic        i_valid,
  output logic [2:0]  o_rs,
  output logic [2:0]  o_rt,
  output logic        o_reading_rs,
  output logic        o_reading_rt
);

  opcode_t w_op;

  assign w_op = i_instr_hi[10:6];
  assign o_rs = i_instr_hi[5:3];
  assign o_rt = i_instr_hi[2:0];

  assign o_reading_rs = i_valid & reads_rs(w_op);
  assign o_reading_rt = i_valid & reads_rt(w_op);

endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID register with stall hold, flush-to-NOP and a
// sticky stall watchdog. Ports: clk, rst, bus (slave); IF_ID_PERF_CNT_EN.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_STALL = 15
`ifdef IF_ID_PERF_CNT_EN
  , parameter int CNT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  if_id_pipe_reg_if.slave  bus
);

  localparam int HC_W = $clog2(MAX_STALL + 1);
  localparam logic [HC_W-1:0] HC_MAX =
    HC_W'(MAX_STALL);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;
  logic              w_squash;
  logic              w_hold;
  logic              w_hold_inc;

  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc;
  logic              r_valid;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_timeout;

  assign w_hold = bus.stall & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_squash    = 1'b0;
    w_hold_inc  = 1'b0;
    unique case (1'b1)
      bus.flush: begin
        w_squash    = 1'b1;
        w_state_nxt = ST_EMPTY;
      end
      w_hold: begin
        unique case (r_state)
          ST_RUN: w_state_nxt = ST_HOLD;
          ST_HOLD: begin
            w_state_nxt = ST_HOLD;
            w_hold_inc  = 1'b1;
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end
      default: begin
        w_load      = 1'b1;
        w_state_nxt = bus.fetch_valid_in ?
                      ST_RUN : ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (w_squash) begin
      r_instr <= NOP;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_instr <= bus.fetch_valid_in ?
                 bus.instr_in : NOP;
      r_pc    <= bus.pc_plus2_in;
      r_valid <= bus.fetch_valid_in;
    end
  end

  // Count only while staying in HOLD; entry and exit both zero it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_hold_inc) begin
        if (r_hold_cnt != HC_MAX)
          r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
      if (r_hold_cnt >= HC_MAX)
        r_timeout <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_hold && r_valid &&
          r_stall_cycles != '1)
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (bus.flush && r_flush_count != '1)
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif

  assign bus.instr_out     = r_instr;
  assign bus.pc_plus2_out  = r_pc;
  assign bus.valid_out     = r_valid;
  assign bus.stall_timeout = r_timeout;

  if_id_src_decode u_dec (
    .i_instr_hi   (r_instr[15:5]),
    .i_valid      (r_valid),
    .o_rs         (bus.Rs_out),
    .o_rt         (bus.Rt_out),
    .o_reading_rs (bus.ReadingRs_out),
    .o_reading_rt (bus.ReadingRt_out)
  );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed and random stimulus for if_id_pipe_reg
// against a cycle-level reference model of the stage.
module tb_if_id_pipe_reg;

  localparam int MAXS = 15;
  localparam logic [15:0] NOPI = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.DATA_W(16)) bus ();

  if_id_pipe_reg #(
    .DATA_W    (16),
    .MAX_STALL (MAXS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] m_instr;
  logic [15:0] m_pc;
  bit          m_valid;
  int          m_held;
  bit          m_to;
  int          m_sc;
  int          m_fc;

  function automatic bit exp_rs(input logic [4:0] op);
    return !(op inside {5'b00000, 5'b00001, 5'b00010,
             5'b00011, 5'b00100, 5'b00110, 5'b11000});
  endfunction

  function automatic bit exp_rt(input logic [4:0] op);
    return op inside {5'b11011, 5'b11010, 5'b11100,
           5'b11101, 5'b11110, 5'b11111, 5'b10000,
           5'b10011};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] op;
    op = m_instr[15:11];
    chk("instr_out", bus.instr_out, m_instr);
    chk("valid_out", bus.valid_out, m_valid);
    if (m_valid)
      chk("pc_plus2_out", bus.pc_plus2_out, m_pc);
    chk("Rs_out", bus.Rs_out, m_instr[10:8]);
    chk("Rt_out", bus.Rt_out, m_instr[7:5]);
    chk("ReadingRs", bus.ReadingRs_out,
        m_valid && exp_rs(op));
    chk("ReadingRt", bus.ReadingRt_out,
        m_valid && exp_rt(op));
    chk("stall_timeout", bus.stall_timeout, m_to);
`ifdef IF_ID_PERF_CNT_EN
    chk("stall_cycles", bus.stall_cycles, m_sc);
    chk("flush_count", bus.flush_count, m_fc);
`endif
  endtask

  // One clock edge: drive, advance the model, compare 1ns later.
  task automatic step(input bit rs,
                      input logic [15:0] ins,
                      input logic [15:0] pc,
                      input bit fv, input bit st,
                      input bit fl);
    rst = rs;
    bus.instr_in       = ins;
    bus.pc_plus2_in    = pc;
    bus.fetch_valid_in = fv;
    bus.stall          = st;
    bus.flush          = fl;
    @(posedge clk);
    if (rs) begin
      m_instr = NOPI;
      m_pc    = '0;
      m_valid = 0;
      m_held  = 0;
      m_to    = 0;
      m_sc    = 0;
      m_fc    = 0;
    end else begin
      // watchdog counts the held edges after the first one
      if (m_held - 1 >= MAXS) m_to = 1;
      if (fl) begin
        m_instr = NOPI;
        m_valid = 0;
        m_held  = 0;
        if (m_fc < 32'hFFFF) m_fc++;
      end else if (st) begin
        if (m_valid) begin
          if (m_held < 1000) m_held++;
          if (m_sc < 32'hFFFF) m_sc++;
        end
      end else begin
        m_instr = fv ? ins : NOPI;
        m_pc    = pc;
        m_valid = fv;
        m_held  = 0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic load(input logic [15:0] ins,
                      input logic [15:0] pc);
    step(0, ins, pc, 1, 0, 0);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++)
      step(0, 16'h1357, 16'h9999, 1, 1, 0);
  endtask

  initial begin
    step(1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    step(1, 16'h0000, 16'h0000, 0, 0, 0);

    load(16'hD9A0, 16'h0002);
    chk("first_Rs", bus.Rs_out, 3'd1);
    chk("first_Rt", bus.Rt_out, 3'd5);
    load(16'h4100, 16'h0004);
    load(16'h0800, 16'h0006);

    load(16'hD9A0, 16'h0010);
    hold(4);
    load(16'h6A40, 16'h0012);

    load(16'h2000, 16'h0020);
    hold(1);
    step(0, 16'hD9A0, 16'h0022, 1, 0, 1);
    chk("flush_instr", bus.instr_out, 16'h0800);

    step(0, 16'h1111, 16'h0030, 0, 1, 0);
    step(0, 16'h2222, 16'h0032, 0, 0, 0);

    load(16'hDB20, 16'h0040);
    hold(3);
    step(0, 16'hDB20, 16'h0042, 1, 1, 1);
    load(16'h8C60, 16'h0044);
    hold(15);
    step(0, 16'h8C60, 16'h0046, 1, 1, 1);
    chk("no_timeout", bus.stall_timeout, 1'b0);

    load(16'hE0E0, 16'h0050);
    hold(16);
    chk("timeout_pre", bus.stall_timeout, 1'b0);
    hold(1);
    chk("timeout_set", bus.stall_timeout, 1'b1);
    load(16'h4100, 16'h0052);
    step(0, 16'h0000, 16'h0054, 1, 0, 1);
    load(16'h9800, 16'h0056);
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    chk("timeout_clr", bus.stall_timeout, 1'b0);

`ifdef IF_ID_PERF_CNT_EN
    load(16'hD9A0, 16'h0060);
    hold(5);
    step(0, 16'h0000, 16'h0062, 1, 0, 1);
    step(0, 16'h0000, 16'h0064, 1, 1, 1);
    chk("perf_stalls", bus.stall_cycles, 5);
    chk("perf_flushes", bus.flush_count, 2);
    step(1, 16'h0000, 16'h0000, 0, 0, 0);
    chk("perf_rst_s", bus.stall_cycles, 0);
    chk("perf_rst_f", bus.flush_count, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0),
           16'($urandom), 16'($urandom),
           ($urandom_range(9) < 8),
           ($urandom_range(9) < 3),
           ($urandom_range(9) == 0));
    end
    load(16'hC000, 16'h0070);
    hold(20);
    load(16'h0000, 16'h0072);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
